sysbus_mem_responder: RTL and testbench

//  Memory-side responder for the Sysbus: the target end that the cache arbiter initiates to.

---
 rtl/sysbus_mem_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_sysbus_mem_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory-side responder: one-beat reads return 8-beat line bursts, address+8-beat write bursts.
// Optional macro SYSBUS_RESP_STALL_EN inserts a one-cycle bubble after read beat 3.
module sysbus_mem_responder #(
    parameter int WIDTH        = 64,
    parameter int TAG_WIDTH    = 13,
    parameter int MEM_WORDS    = 4096,
    parameter int READ_LATENCY = 4,
    parameter int BURST_LEN    = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     req,
    input  logic [TAG_WIDTH-1:0] reqtag,
    input  logic                 reqcyc,
    output logic                 reqack,
    output logic [WIDTH-1:0]     resp,
    output logic [TAG_WIDTH-1:0] resptag,
    output logic                 respcyc,
    input  logic                 respack,
    output logic                 busy
);

    localparam int AW    = $clog2(MEM_WORDS);
    localparam int LW    = AW - 3;
    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_BURST = 2'd2,
        WR_DATA  = 2'd3
    } state_t;

    state_t               state_r, state_nxt_s;
    logic [LW-1:0]        line_r, line_nxt_s;
    logic [TAG_WIDTH-1:0] tag_r, tag_nxt_s;
    logic [LAT_W-1:0]     lat_r, lat_nxt_s;
    logic [2:0]           beat_r, beat_nxt_s, rd_beat_s;
    logic                 bubble_r, bubble_nxt_s;
    logic                 respcyc_r, respcyc_nxt_s;
    logic [WIDTH-1:0]     resp_r, resp_nxt_s;
    logic                 reqack_r, busy_r;
    logic                 accept_s, mem_we_s;
    logic [WIDTH-1:0]     mem_rd_s;
    logic [WIDTH-1:0]     mem_r [MEM_WORDS];

    // A beat is only taken outside the reqack cycle and in a state that consumes request beats.
    assign accept_s = reqcyc && !reqack_r && ((state_r == IDLE) || (state_r == WR_DATA));
    assign mem_rd_s = mem_r[{line_r, rd_beat_s}];

    assign reqack  = reqack_r;
    assign resp    = resp_r;
    assign resptag = tag_r;
    assign respcyc = respcyc_r;
    assign busy    = busy_r;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = reqtag[TAG_WIDTH-1] ? RD_WAIT : WR_DATA;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD_WAIT: begin
                if (lat_r == LAT_W'(1)) begin
                    state_nxt_s = RD_BURST;
                end else begin
                    state_nxt_s = RD_WAIT;
                end
            end
            RD_BURST: begin
                if (respcyc_r && respack && (beat_r == LAST_BEAT)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RD_BURST;
                end
            end
            WR_DATA: begin
                if (accept_s && (beat_r == LAST_BEAT)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WR_DATA;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Beat offset of the word the next response will carry
    always_comb begin
        rd_beat_s = beat_r + 3'd1;
        case (state_r)
            RD_WAIT: rd_beat_s = 3'd0;
            RD_BURST: begin
                if (bubble_r) begin
                    rd_beat_s = beat_r;
                end else begin
                    rd_beat_s = beat_r + 3'd1;
                end
            end
            default: rd_beat_s = beat_r + 3'd1;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        line_nxt_s    = line_r;
        tag_nxt_s     = tag_r;
        lat_nxt_s     = lat_r;
        beat_nxt_s    = beat_r;
        bubble_nxt_s  = bubble_r;
        respcyc_nxt_s = respcyc_r;
        resp_nxt_s    = resp_r;
        mem_we_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    line_nxt_s = req[AW+2:6];
                    beat_nxt_s = 3'd0;
                    if (reqtag[TAG_WIDTH-1]) begin
                        tag_nxt_s = reqtag;
                        lat_nxt_s = LAT_W'(READ_LATENCY);
                    end else begin
                        tag_nxt_s = tag_r;
                    end
                end else begin
                    line_nxt_s = line_r;
                end
            end
            RD_WAIT: begin
                lat_nxt_s = lat_r - LAT_W'(1);
                if (lat_r == LAT_W'(1)) begin
                    respcyc_nxt_s = 1'b1;
                    resp_nxt_s    = mem_rd_s;
                    beat_nxt_s    = 3'd0;
                end else begin
                    respcyc_nxt_s = 1'b0;
                end
            end
            RD_BURST: begin
                if (bubble_r) begin
                    bubble_nxt_s  = 1'b0;
                    respcyc_nxt_s = 1'b1;
                    resp_nxt_s    = mem_rd_s;
                end else if (respcyc_r && respack) begin
                    if (beat_r == LAST_BEAT) begin
                        respcyc_nxt_s = 1'b0;
                        resp_nxt_s    = '1;
                    end else begin
                        beat_nxt_s = beat_r + 3'd1;
`ifdef SYSBUS_RESP_STALL_EN
                        if (beat_r == 3'd3) begin
                            bubble_nxt_s  = 1'b1;
                            respcyc_nxt_s = 1'b0;
                            resp_nxt_s    = '1;
                        end else begin
                            resp_nxt_s = mem_rd_s;
                        end
`else
                        resp_nxt_s = mem_rd_s;
`endif
                    end
                end else begin
                    resp_nxt_s = resp_r;
                end
            end
            WR_DATA: begin
                if (accept_s) begin
                    mem_we_s   = 1'b1;
                    beat_nxt_s = beat_r + 3'd1;
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            default: begin
                respcyc_nxt_s = 1'b0;
                resp_nxt_s    = '1;
            end
        endcase
    end

    // Datapath and registered bus outputs; reset aborts any burst in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_r    <= '0;
            tag_r     <= '0;
            lat_r     <= '0;
            beat_r    <= 3'd0;
            bubble_r  <= 1'b0;
            respcyc_r <= 1'b0;
            resp_r    <= '1;
            reqack_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            line_r    <= line_nxt_s;
            tag_r     <= tag_nxt_s;
            lat_r     <= lat_nxt_s;
            beat_r    <= beat_nxt_s;
            bubble_r  <= bubble_nxt_s;
            respcyc_r <= respcyc_nxt_s;
            resp_r    <= resp_nxt_s;
            reqack_r  <= accept_s;
            busy_r    <= (state_nxt_s != IDLE);
        end
    end

    // Backing store write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[{line_r, beat_r}] <= req;
        end
    end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed self-checking bench for sysbus_mem_responder (default parameters).
// Expected stall pattern follows SYSBUS_RESP_STALL_EN when the bench is built with it.
module tb_sysbus_mem_responder;

    logic        clk;
    logic        reset_n;
    logic [63:0] req;
    logic [12:0] reqtag;
    logic        reqcyc;
    logic        reqack;
    logic [63:0] resp;
    logic [12:0] resptag;
    logic        respcyc;
    logic        respack;
    logic        busy;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          wr_acks;
    int          acc;
    int          plen;
    logic [31:0] pat;
    logic [12:0] tag_seen;
    bit          rd_timeout;
    logic [63:0] smp_q[$];

`ifdef SYSBUS_RESP_STALL_EN
    localparam logic [31:0] EXP_PAT  = 32'h0000_01EF;
    localparam int          EXP_PLEN = 9;
`else
    localparam logic [31:0] EXP_PAT  = 32'h0000_00FF;
    localparam int          EXP_PLEN = 8;
`endif

    sysbus_mem_responder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .reqtag  (reqtag),
        .reqcyc  (reqcyc),
        .reqack  (reqack),
        .resp    (resp),
        .resptag (resptag),
        .respcyc (respcyc),
        .respack (respack),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one beat and wait (bounded) for its reqack pulse; returns at the sample showing it.
    task automatic send_beat(input logic [63:0] d, input logic [12:0] t, output bit ok);
        ok     = 1'b0;
        req    = d;
        reqtag = t;
        reqcyc = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (reqack === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        reqcyc = 1'b0;
    endtask

    task automatic write_line(input logic [63:0] addr, input logic [63:0] d0);
        bit ok;
        wr_acks = 0;
        send_beat(addr, 13'h0000, ok);
        if (ok) wr_acks++;
        for (int i = 0; i < 8; i++) begin
            send_beat(d0 + 64'(i), 13'h0000, ok);
            if (ok) wr_acks++;
        end
    endtask

    // Sample-then-wait collector; optionally withholds respack for stall_len cycles at stall_beat.
    task automatic collect_burst(input int stall_beat, input int stall_len);
        int stalled;
        bit started;
        smp_q.delete();
        acc = 0; plen = 0; pat = 32'h0; stalled = 0; started = 1'b0;
        tag_seen = 13'h0; respack = 1'b1;
        for (int i = 0; i < 100 && acc < 8; i++) begin
            if (respcyc === 1'b1) begin
                if (!started) tag_seen = resptag;
                started = 1'b1;
                smp_q.push_back(resp);
                if (acc == stall_beat && stalled < stall_len) begin
                    respack = 1'b0;
                    stalled++;
                end else begin
                    respack = 1'b1;
                    acc++;
                end
            end else begin
                respack = 1'b1;
            end
            if (started) begin
                pat = {pat[30:0], respcyc};
                plen++;
            end
            @(negedge clk);
        end
        rd_timeout = (acc != 8);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; reqcyc = 1'b0; respack = 1'b0; req = 64'h0; reqtag = 13'h0;
        repeat (2) @(negedge clk);
        total_cnt++; if (reqack !== 1'b0) $display("FAIL rst_reqack got %b want 0", reqack); else pass_cnt++;
        total_cnt++; if (respcyc !== 1'b0) $display("FAIL rst_respcyc got %b want 0", respcyc); else pass_cnt++;
        total_cnt++; if (resp !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL rst_resp got %h want all ones", resp); else pass_cnt++;
        total_cnt++; if (resptag !== 13'h0) $display("FAIL rst_resptag got %h want 0", resptag); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_cnt++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_read();
        bit ok;
        write_line(64'h40, 64'h1000);
        total_cnt++; if (wr_acks != 9) $display("FAIL wr_acks got %0d want 9", wr_acks); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL wr_busy_drop got %b want 0", busy); else pass_cnt++;
        send_beat(64'h40, 13'h1005, ok);
        total_cnt++; if (!ok) $display("FAIL wr_rd_accept got 0 want 1"); else pass_cnt++;
        collect_burst(-1, 0);
        total_cnt++; if (rd_timeout) $display("FAIL wr_rd_beats got %0d want 8", acc); else pass_cnt++;
        for (int i = 0; i < 8 && i < smp_q.size(); i++) begin
            total_cnt++;
            if (smp_q[i] !== 64'h1000 + 64'(i)) $display("FAIL wr_rd_data[%0d] got %h want %h", i, smp_q[i], 64'h1000 + 64'(i));
            else pass_cnt++;
        end
        total_cnt++; if (tag_seen !== 13'h1005) $display("FAIL wr_rd_tag got %h want 1005", tag_seen); else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read_latency();
        bit early;
        early = 1'b0;
        req = 64'h40; reqtag = 13'h1001; reqcyc = 1'b1; respack = 1'b1;
        @(negedge clk);
        total_cnt++; if (reqack !== 1'b1) $display("FAIL lat_reqack got %b want 1", reqack); else pass_cnt++;
        reqcyc = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (respcyc !== 1'b0) early = 1'b1;
        end
        @(negedge clk);
        total_cnt++; if (early) $display("FAIL lat_early got respcyc before 4 cycles want later"); else pass_cnt++;
        total_cnt++; if (respcyc !== 1'b1) $display("FAIL lat_first got %b want 1", respcyc); else pass_cnt++;
        collect_burst(-1, 0);
        total_cnt++; if (acc != 8) $display("FAIL lat_beats got %0d want 8", acc); else pass_cnt++;
        total_cnt++;
        if (pat !== EXP_PAT || plen != EXP_PLEN) $display("FAIL lat_pattern got %h/%0d want %h/%0d", pat, plen, EXP_PAT, EXP_PLEN);
        else pass_cnt++;
        total_cnt++; if (respcyc !== 1'b0) $display("FAIL lat_end_respcyc got %b want 0", respcyc); else pass_cnt++;
        total_cnt++; if (resp !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL lat_end_resp got %h want all ones", resp); else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit ok;
        write_line(64'h1C0, 64'hA0);
        send_beat(64'h1C0, 13'h1111, ok);
        collect_burst(5, 3);
        total_cnt++; if (rd_timeout) $display("FAIL bp_beats got %0d want 8", acc); else pass_cnt++;
        total_cnt++; if (smp_q.size() != 11) $display("FAIL bp_samples got %0d want 11", smp_q.size()); else pass_cnt++;
        if (smp_q.size() == 11) begin
            for (int i = 5; i <= 8; i++) begin
                total_cnt++;
                if (smp_q[i] !== 64'hA5) $display("FAIL bp_hold[%0d] got %h want a5", i, smp_q[i]); else pass_cnt++;
            end
            total_cnt++; if (smp_q[10] !== 64'hA7) $display("FAIL bp_last got %h want a7", smp_q[10]); else pass_cnt++;
        end
        total_cnt++; if (respcyc !== 1'b0) $display("FAIL bp_end got %b want 0", respcyc); else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wrap_collision();
        bit ok;
        bit ack_seen;
        int acc_at_ack;
        write_line(64'h0, 64'h5000);
        send_beat(64'h8_0000, 13'h1ABC, ok);
        smp_q.delete();
        acc = 0; ack_seen = 1'b0; acc_at_ack = -1; tag_seen = 13'h0;
        req = 64'h40; reqtag = 13'h1003; reqcyc = 1'b1; respack = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (respcyc === 1'b1) begin
                if (acc == 0) tag_seen = resptag;
                smp_q.push_back(resp);
                acc++;
            end
            if (reqack === 1'b1) begin
                ack_seen = 1'b1;
                acc_at_ack = acc;
                break;
            end
        end
        reqcyc = 1'b0;
        total_cnt++; if (!ack_seen) $display("FAIL col_ack got none want 1"); else pass_cnt++;
        total_cnt++; if (acc_at_ack != 8) $display("FAIL col_ack_when got beats %0d want 8", acc_at_ack); else pass_cnt++;
        total_cnt++; if (tag_seen !== 13'h1ABC) $display("FAIL wrap_tag got %h want 1abc", tag_seen); else pass_cnt++;
        for (int i = 0; i < 8 && i < smp_q.size(); i++) begin
            total_cnt++;
            if (smp_q[i] !== 64'h5000 + 64'(i)) $display("FAIL wrap_data[%0d] got %h want %h", i, smp_q[i], 64'h5000 + 64'(i));
            else pass_cnt++;
        end
        collect_burst(-1, 0);
        total_cnt++; if (rd_timeout) $display("FAIL col_second_beats got %0d want 8", acc); else pass_cnt++;
        total_cnt++; if (tag_seen !== 13'h1003) $display("FAIL col_second_tag got %h want 1003", tag_seen); else pass_cnt++;
        if (smp_q.size() > 7) begin
            total_cnt++; if (smp_q[0] !== 64'h1000) $display("FAIL col_second_d0 got %h want 1000", smp_q[0]); else pass_cnt++;
            total_cnt++; if (smp_q[7] !== 64'h1007) $display("FAIL col_second_d7 got %h want 1007", smp_q[7]); else pass_cnt++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        bit found;
        bit stray;
        send_beat(64'h40, 13'h1007, ok);
        respack = 1'b1; acc = 0; found = 1'b0; stray = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (respcyc === 1'b1 && acc == 2) begin
                found = 1'b1;
                break;
            end
            if (respcyc === 1'b1) acc++;
            @(negedge clk);
        end
        total_cnt++; if (!found) $display("FAIL mid_reach_beat2 got none want beat 2"); else pass_cnt++;
        total_cnt++; if (resp !== 64'h1002) $display("FAIL mid_beat2 got %h want 1002", resp); else pass_cnt++;
        #2 reset_n = 1'b0;
        #1;
        total_cnt++; if (respcyc !== 1'b0) $display("FAIL mid_rst_respcyc got %b want 0", respcyc); else pass_cnt++;
        total_cnt++; if (resp !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL mid_rst_resp got %h want all ones", resp); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", busy); else pass_cnt++;
        #1 reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (respcyc !== 1'b0) stray = 1'b1;
        end
        total_cnt++; if (stray) $display("FAIL mid_no_more_beats got respcyc=1 want 0"); else pass_cnt++;
        send_beat(64'h40, 13'h1002, ok);
        collect_burst(-1, 0);
        total_cnt++; if (rd_timeout) $display("FAIL mid_next_beats got %0d want 8", acc); else pass_cnt++;
        if (smp_q.size() > 7) begin
            total_cnt++; if (smp_q[0] !== 64'h1000) $display("FAIL mid_next_d0 got %h want 1000", smp_q[0]); else pass_cnt++;
            total_cnt++; if (smp_q[7] !== 64'h1007) $display("FAIL mid_next_d7 got %h want 1007", smp_q[7]); else pass_cnt++;
        end
        total_cnt++; if (tag_seen !== 13'h1002) $display("FAIL mid_next_tag got %h want 1002", tag_seen); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_latency();
        test_backpressure();
        test_wrap_collision();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
